usb_tx: RTL and testbench

USB_TX -- requirements
Module: usb_tx

---
 rtl/usb_pkg.sv | 34 +++
 rtl/usb_crc16.sv | 27 ++
 rtl/usb_tx.sv | 211 +++++++++++++++++++++
 tb/tb_usb_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB TX definitions: request codes, FSM states, SYNC/PID bytes and CRC16 constants.
package usb_pkg;

    typedef enum logic [2:0] {
        PktNone  = 3'd0,
        PktData0 = 3'd1,
        PktAck   = 3'd2,
        PktNak   = 3'd3,
        PktStall = 3'd4
    } tx_pkt_e;

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J
    } tx_state_e;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  PID_ACK    = 8'hD2;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [7:0]  PID_STALL  = 8'h1E;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [7:0] pid_byte(input tx_pkt_e pkt);
        case (pkt)
            PktData0: return PID_DATA0;
            PktAck:   return PID_ACK;
            PktNak:   return PID_NAK;
            PktStall: return PID_STALL;
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (x^16+x^15+x^2+1), one data bit per shift_en, bits in transmission order.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        data_bit,
    output logic [15:0] crc
);

    logic w_fb;

    assign w_fb = crc[15] ^ data_bit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (shift_en) begin
            crc <= {crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx.sv
// USB packet serialiser: SYNC, PID, optional DATA0 payload + CRC16, then SE0/SE0/J EOP.
// Bit stuffing is compiled in only when USB_TX_BIT_STUFF_EN is defined.
module usb_tx
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_transfer_active,
    output logic       tx_error
);

    localparam int unsigned     CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
`ifdef USB_TX_BIT_STUFF_EN
    localparam bit StuffEn = 1'b1;
`else
    localparam bit StuffEn = 1'b0;
`endif

    tx_state_e       r_state, w_state_nxt;
    tx_pkt_e         r_pkt, w_pkt_nxt;
    logic [CntW-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [6:0]      r_byte_cnt, w_byte_cnt_nxt;
    logic [2:0]      r_ones, w_ones_nxt;
    logic            r_dp, w_dp_nxt;
    logic            r_dm, w_dm_nxt;
    logic            r_active, w_active_nxt;
    logic            r_err, w_err_nxt;

    logic            w_bit_end, w_in_pkt, w_launch, w_bit, w_get;
    logic            w_crc_clear, w_crc_shift;
    logic [15:0]     w_crc, w_crc_tx;

    usb_crc16 u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (w_crc_clear),
        .shift_en (w_crc_shift),
        .data_bit (w_bit),
        .crc      (w_crc)
    );

    // Transmitted CRC is the complemented register, MSB first on the wire.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_crc_tx[i] = ~w_crc[15 - i];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_pkt      <= PktNone;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_ones     <= '0;
            r_dp       <= 1'b1;
            r_dm       <= 1'b0;
            r_active   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pkt      <= w_pkt_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_ones     <= w_ones_nxt;
            r_dp       <= w_dp_nxt;
            r_dm       <= w_dm_nxt;
            r_active   <= w_active_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pkt_nxt      = r_pkt;
        w_clk_cnt_nxt  = r_clk_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_byte_cnt_nxt = r_byte_cnt;
        w_ones_nxt     = r_ones;
        w_dp_nxt       = r_dp;
        w_dm_nxt       = r_dm;
        w_active_nxt   = r_active;
        w_err_nxt      = 1'b0;
        w_launch       = 1'b0;
        w_bit          = 1'b0;
        w_get          = 1'b0;
        w_crc_clear    = 1'b0;
        w_crc_shift    = 1'b0;
        w_bit_end      = (r_clk_cnt == CntMax);
        w_in_pkt       = (r_state == SYNC) || (r_state == PID) || (r_state == DATA) ||
                         (r_state == CRC_LO) || (r_state == CRC_HI);

        if (r_state == IDLE) begin
            if ((tx_packet != 3'd0) && (tx_packet <= 3'd4)) begin
                w_state_nxt    = SYNC;
                w_pkt_nxt      = tx_pkt_e'(tx_packet);
                w_clk_cnt_nxt  = '0;
                w_bit_idx_nxt  = '0;
                w_shift_nxt    = SYNC_BYTE;
                w_byte_cnt_nxt = buffer_occupancy;
                w_active_nxt   = 1'b1;
                w_crc_clear    = 1'b1;
                w_launch       = 1'b1;
                w_bit          = SYNC_BYTE[0];
            end else if (tx_packet > 3'd4) begin
                w_err_nxt = 1'b1;
            end
        end else begin
            w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;
            if (w_bit_end) begin
                if (StuffEn && w_in_pkt && (r_ones == 3'd6)) begin
                    // Stuffed zero: the bit position does not advance.
                    w_launch = 1'b1;
                    w_bit    = 1'b0;
                end else if (w_in_pkt && (r_bit_idx != 3'd7)) begin
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    w_launch      = 1'b1;
                    w_bit         = r_shift[r_bit_idx + 3'd1];
                    w_crc_shift   = (r_state == DATA);
                end else begin
                    w_bit_idx_nxt = '0;
                    case (r_state)
                        SYNC: begin
                            w_state_nxt = PID;
                            w_shift_nxt = pid_byte(r_pkt);
                            w_launch    = 1'b1;
                            w_bit       = w_shift_nxt[0];
                        end
                        PID, DATA: begin
                            if ((r_state == PID) && (r_pkt != PktData0)) begin
                                w_state_nxt = EOP_SE0;
                                w_dp_nxt    = 1'b0;
                                w_dm_nxt    = 1'b0;
                            end else if (r_byte_cnt != '0) begin
                                w_state_nxt    = DATA;
                                w_get          = 1'b1;
                                w_shift_nxt    = tx_packet_data;
                                w_byte_cnt_nxt = r_byte_cnt - 7'd1;
                                w_launch       = 1'b1;
                                w_bit          = tx_packet_data[0];
                                w_crc_shift    = 1'b1;
                            end else begin
                                w_state_nxt = CRC_LO;
                                w_shift_nxt = w_crc_tx[7:0];
                                w_launch    = 1'b1;
                                w_bit       = w_crc_tx[0];
                            end
                        end
                        CRC_LO: begin
                            w_state_nxt = CRC_HI;
                            w_shift_nxt = w_crc_tx[15:8];
                            w_launch    = 1'b1;
                            w_bit       = w_crc_tx[8];
                        end
                        CRC_HI: begin
                            w_state_nxt = EOP_SE0;
                            w_dp_nxt    = 1'b0;
                            w_dm_nxt    = 1'b0;
                        end
                        EOP_SE0: begin
                            if (r_bit_idx == 3'd0) begin
                                w_bit_idx_nxt = 3'd1;
                            end else begin
                                w_state_nxt = EOP_J;
                                w_dp_nxt    = 1'b1;
                                w_dm_nxt    = 1'b0;
                            end
                        end
                        EOP_J: begin
                            w_state_nxt  = IDLE;
                            w_active_nxt = 1'b0;
                        end
                        default: w_state_nxt = IDLE;
                    endcase
                end
            end
        end

        // NRZI: a zero toggles both lines, a one holds them.
        if (w_launch) begin
            if (!w_bit) begin
                w_dp_nxt = ~r_dp;
                w_dm_nxt = ~r_dm;
            end
            w_ones_nxt = w_bit ? r_ones + 3'd1 : 3'd0;
        end
    end

    assign get_tx_packet_data = w_get;
    assign d_plus             = r_dp;
    assign d_minus            = r_dm;
    assign tx_transfer_active = r_active;
    assign tx_error           = r_err;

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: a spec-level packet model fills expectation queues and a
// line monitor decodes NRZI/stuffing and checks every bit, length, pop count and CRC residual.
module tb_usb_tx;

    localparam int CPB = 8;
`ifdef USB_TX_BIT_STUFF_EN
    localparam bit TbStuff = 1'b1;
`else
    localparam bit TbStuff = 1'b0;
`endif

    logic       clk;
    logic       n_rst;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic       d_plus;
    logic       d_minus;
    logic       tx_transfer_active;
    logic       tx_error;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    usb_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .d_plus             (d_plus),
        .d_minus            (d_minus),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    // TX buffer: head byte advances on every pop pulse.
    logic [7:0] buf_mem [64];
    int         gets_total;
    int         buf_base;
    assign tx_packet_data = buf_mem[6'(gets_total - buf_base)];
    always @(posedge clk) if (get_tx_packet_data) gets_total <= gets_total + 1;

    logic [1:0] exp_lvl_q [$];
    int         exp_len_q [$];
    int         exp_get_q [$];
    int         exp_nb_q  [$];
    logic [7:0] exp_byte_q[$];
    int         n_vec;
    int         n_err;
    bit         mon_en;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected packet from the protocol rules: byte list, bytewise reflected CRC, stuffing, NRZI.
    task automatic model_push(input logic [2:0] code, input int n);
        logic [7:0]  bytes[$];
        logic [1:0]  lvl;
        int unsigned r;
        int          ones;
        int          nbits;
        bit          v;
        bytes.push_back(8'h80);
        case (code)
            3'd1:    bytes.push_back(8'hC3);
            3'd2:    bytes.push_back(8'hD2);
            3'd3:    bytes.push_back(8'h5A);
            default: bytes.push_back(8'h1E);
        endcase
        if (code == 3'd1) begin
            r = 32'hFFFF;
            for (int i = 0; i < n; i++) begin
                bytes.push_back(buf_mem[i]);
                r = r ^ 32'(buf_mem[i]);
                for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hA001) : (r >> 1);
            end
            r = ~r & 32'hFFFF;
            bytes.push_back(r[7:0]);
            bytes.push_back(r[15:8]);
        end
        exp_nb_q.push_back(bytes.size());
        lvl   = 2'b10;
        ones  = 0;
        nbits = 0;
        foreach (bytes[i]) begin
            exp_byte_q.push_back(bytes[i]);
            for (int b = 0; b < 8; b++) begin
                v = bytes[i][b];
                if (!v) lvl = ~lvl;
                exp_lvl_q.push_back(lvl);
                nbits++;
                ones = v ? ones + 1 : 0;
                if (TbStuff && ones == 6) begin
                    lvl = ~lvl;
                    exp_lvl_q.push_back(lvl);
                    nbits++;
                    ones = 0;
                end
            end
        end
        exp_lvl_q.push_back(2'b00);
        exp_lvl_q.push_back(2'b00);
        exp_lvl_q.push_back(2'b10);
        nbits += 3;
        exp_len_q.push_back(nbits * CPB);
        exp_get_q.push_back((code == 3'd1) ? n : 0);
    endtask

    task automatic request(input logic [2:0] code, input int n);
        @(negedge clk);
        tx_packet        = code;
        buffer_occupancy = 7'(n);
        @(negedge clk);
        tx_packet        = 3'd0;
        buffer_occupancy = 7'($urandom_range(0, 64));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20000; i++) begin
            if (!tx_transfer_active) break;
            @(negedge clk);
        end
        if (tx_transfer_active) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: tx_transfer_active got 1, want 0");
        end
    endtask

    task automatic send(input logic [2:0] code, input int n);
        buf_base = gets_total;
        model_push(code, n);
        request(code, n);
        chk("accepted", int'(tx_transfer_active), 1);
        wait_done();
        repeat ($urandom_range(1, 4)) @(negedge clk);
        chk("idle_lines", int'({d_plus, d_minus}), 2);
    endtask

    // Monitor: samples mid-bit while active, compares line levels and decodes the packet.
    initial begin : monitor
        logic [1:0] lvl, prev;
        logic [7:0] acc;
        logic [7:0] dec[$];
        logic [15:0] r16, rev;
        int unsigned r;
        int cyc, gets, nb, ones, nb_exp, a;
        bit was_act, en, in_eop, b;
        was_act = 1'b0;
        en      = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_transfer_active && !was_act) begin
                en = mon_en; cyc = 0; gets = 0; nb = 0; ones = 0;
                prev = 2'b10; in_eop = 1'b0; dec.delete();
            end
            if (tx_transfer_active) begin
                if (get_tx_packet_data) gets++;
                if (en && (cyc % CPB) == (CPB / 2)) begin
                    lvl = {d_plus, d_minus};
                    if (exp_lvl_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL line_bit: got 0x%0h, want no bit", lvl);
                    end else begin
                        chk("line_bit", int'(lvl), int'(exp_lvl_q.pop_front()));
                    end
                    if (lvl == 2'b00) begin
                        in_eop = 1'b1;
                    end else if (!in_eop) begin
                        b = (lvl == prev);
                        prev = lvl;
                        if (TbStuff && ones == 6) begin
                            ones = 0;
                        end else begin
                            acc[3'(nb % 8)] = b;
                            nb++;
                            if (nb % 8 == 0) dec.push_back(acc);
                            ones = b ? ones + 1 : 0;
                        end
                    end
                end
                cyc++;
            end else if (was_act && en) begin
                if (exp_len_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL packet: got an unexpected packet, want none");
                end else begin
                    chk("active_cycles", cyc, exp_len_q.pop_front());
                    chk("get_pulses", gets, exp_get_q.pop_front());
                    nb_exp = exp_nb_q.pop_front();
                    chk("byte_count", dec.size(), nb_exp);
                    for (int i = 0; i < nb_exp; i++) begin
                        a = (i < dec.size()) ? int'(dec[i]) : -1;
                        chk("dec_byte", a, int'(exp_byte_q.pop_front()));
                    end
                    if (dec.size() >= 4 && dec[1] == 8'hC3) begin
                        r = 32'hFFFF;
                        for (int i = 2; i < dec.size(); i++) begin
                            r = r ^ 32'(dec[i]);
                            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hA001) : (r >> 1);
                        end
                        r16 = r[15:0];
                        rev = {<<{r16}};
                        chk("crc_residual", int'(rev), 16'h800D);
                    end
                end
            end
            was_act = tx_transfer_active;
        end
    end

    initial begin : stimulus
        n_rst            = 1'b0;
        tx_packet        = 3'd0;
        buffer_occupancy = 7'd0;
        mon_en           = 1'b1;
        foreach (buf_mem[i]) buf_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_dplus",  int'(d_plus), 1);
        chk("rst_dminus", int'(d_minus), 0);
        chk("rst_active", int'(tx_transfer_active), 0);
        chk("rst_get",    int'(get_tx_packet_data), 0);
        chk("rst_error",  int'(tx_error), 0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_lines", int'({d_plus, d_minus}), 2);

        send(3'd2, 0);
        buf_mem[0] = 8'hAA;
        buf_mem[1] = 8'hAF;
        send(3'd1, 2);
        send(3'd1, 0);
        buf_mem[0] = 8'hFF;
        send(3'd1, 1);
        send(3'd3, 0);
        send(3'd4, 0);

        // Invalid request in IDLE.
        @(negedge clk);
        tx_packet = 3'b110;
        @(negedge clk);
        tx_packet = 3'd0;
        chk("err_pulse", int'(tx_error), 1);
        chk("err_no_active", int'(tx_transfer_active), 0);
        chk("err_lines", int'({d_plus, d_minus}), 2);
        @(negedge clk);
        chk("err_one_cycle", int'(tx_error), 0);

        // Requests while busy are ignored.
        for (int i = 0; i < 5; i++) buf_mem[i] = 8'($urandom);
        buf_base = gets_total;
        model_push(3'd1, 5);
        request(3'd1, 5);
        repeat (40) @(negedge clk);
        tx_packet = 3'd2;
        @(negedge clk);
        tx_packet = 3'b111;
        @(negedge clk);
        tx_packet = 3'd0;
        chk("busy_no_error", int'(tx_error), 0);
        wait_done();
        repeat (2) @(negedge clk);

        // Reset in the middle of the first data byte, then ACK on the first edge after release.
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) buf_mem[i] = 8'($urandom);
        buf_base = gets_total;
        request(3'd1, 4);
        repeat (20 * CPB) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_dplus",  int'(d_plus), 1);
        chk("midrst_dminus", int'(d_minus), 0);
        chk("midrst_active", int'(tx_transfer_active), 0);
        chk("midrst_get",    int'(get_tx_packet_data), 0);
        @(negedge clk);
        n_rst     = 1'b1;
        mon_en    = 1'b1;
        model_push(3'd2, 0);
        tx_packet = 3'd2;
        @(negedge clk);
        tx_packet = 3'd0;
        chk("post_rst_accept", int'(tx_transfer_active), 1);
        wait_done();
        repeat (2) @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            int code, n;
            code = $urandom_range(1, 4);
            n    = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) buf_mem[i] = 8'($urandom);
            send(3'(code), n);
        end
        for (int i = 0; i < 64; i++) buf_mem[i] = 8'($urandom);
        send(3'd1, 64);

        repeat (4) @(negedge clk);
        chk("queues_drained", exp_lvl_q.size() + exp_len_q.size() + exp_byte_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
